// File: rtl/out_sig_reducer_if.sv
// Channel-side and probe-side signals of out_sig_reducer.
// The kernel/observer side takes the master modport; the reducer takes the slave modport.
interface out_sig_reducer_if #(
    parameter int NUM_CH     = 4,
    parameter int DIN_WIDTH  = 32,
    parameter int FOLD_WIDTH = 8,
    parameter int OUT_WIDTH  = 4,
    parameter int CNT_WIDTH  = 32
);
    logic [NUM_CH*DIN_WIDTH-1:0] ch_din;
    logic [NUM_CH-1:0]           ch_write;
    logic                        run_start;
    logic                        run_done;
    logic [OUT_WIDTH-1:0]        data_out;
    logic                        data_valid;
    logic [FOLD_WIDTH-1:0]       sig_out;
    logic [CNT_WIDTH-1:0]        beat_cnt;
    logic                        sig_valid;

    modport master (
        output ch_din, ch_write, run_start, run_done,
        input  data_out, data_valid, sig_out, beat_cnt, sig_valid
    );

    modport slave (
        input  ch_din, ch_write, run_start, run_done,
        output data_out, data_valid, sig_out, beat_cnt, sig_valid
    );
endinterface

// File: rtl/out_sig_reducer.sv
// Folds NUM_CH output-channel words into a per-beat XOR code through a valid-masked
// reduction tree, and keeps a per-run rotating signature plus a saturating beat count.
module out_sig_reducer #(
    parameter int NUM_CH     = 4,
    parameter int DIN_WIDTH  = 32,
    parameter int FOLD_WIDTH = 8,
    parameter int OUT_WIDTH  = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    out_sig_reducer_if.slave bus
);
    // Node count of tree level s (level 0 is the per-channel fold register).
    function automatic int lvl_nodes(input int s);
        return (NUM_CH + (1 << s) - 1) >> s;
    endfunction

    function automatic int lvl_base(input int s);
        int b;
        b = 0;
        for (int k = 0; k < s; k++) b = b + lvl_nodes(k);
        return b;
    endfunction

    localparam int TREE_STAGES = (NUM_CH > 1) ? $clog2(NUM_CH) : 0;
    localparam int LATENCY     = TREE_STAGES + 2;
    localparam int DONE_DLY    = LATENCY - 1;
    localparam int DIN_SLICES  = DIN_WIDTH / FOLD_WIDTH;
    localparam int OUT_SLICES  = FOLD_WIDTH / OUT_WIDTH;
    localparam int TOTAL_NODES = lvl_base(TREE_STAGES + 1);
    localparam int ROOT        = lvl_base(TREE_STAGES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    function automatic logic [FOLD_WIDTH-1:0] fold_din(input logic [DIN_WIDTH-1:0] word);
        logic [FOLD_WIDTH-1:0] acc;
        acc = '0;
        for (int k = 0; k < DIN_SLICES; k++) acc = acc ^ word[k*FOLD_WIDTH +: FOLD_WIDTH];
        return acc;
    endfunction

    function automatic logic [OUT_WIDTH-1:0] fold_out(input logic [FOLD_WIDTH-1:0] v);
        logic [OUT_WIDTH-1:0] acc;
        acc = '0;
        for (int k = 0; k < OUT_SLICES; k++) acc = acc ^ v[k*OUT_WIDTH +: OUT_WIDTH];
        return acc;
    endfunction

    function automatic logic [FOLD_WIDTH-1:0] rotl1(input logic [FOLD_WIDTH-1:0] v);
        return (v << 1) | (v >> (FOLD_WIDTH - 1));
    endfunction

    // Flat view of every tree node, level by level, starting at lvl_base(level).
    logic                  w_node_v [TOTAL_NODES];
    logic [FOLD_WIDTH-1:0] w_node_d [TOTAL_NODES];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic                  r_v;
        logic [FOLD_WIDTH-1:0] r_d;

        // NOTE: datapath registers are reset along with their valids, so a
        // flushed pipeline never leaves stale codes visible on the probe pins.
        always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
                r_v <= 1'b0;
                r_d <= '0;
            end else begin
                r_v <= bus.ch_write[i];
                r_d <= fold_din(bus.ch_din[i*DIN_WIDTH +: DIN_WIDTH]);
            end
        end

        assign w_node_v[i] = r_v;
        assign w_node_d[i] = r_d;
    end

    for (genvar s = 1; s <= TREE_STAGES; s++) begin : g_lvl
        for (genvar j = 0; j < lvl_nodes(s); j++) begin : g_node
            localparam int SRC = lvl_base(s - 1) + 2 * j;
            localparam int DST = lvl_base(s) + j;

            logic                  r_v;
            logic [FOLD_WIDTH-1:0] r_d;

            if (2 * j + 1 < lvl_nodes(s - 1)) begin : g_pair
                // An invalid operand contributes nothing, so the root is the XOR of valid folds.
                always_ff @(posedge ap_clk) begin
                    if (ap_rst) begin
                        r_v <= 1'b0;
                        r_d <= '0;
                    end else begin
                        r_v <= w_node_v[SRC] | w_node_v[SRC+1];
                        case ({w_node_v[SRC], w_node_v[SRC+1]})
                            2'b11:   r_d <= w_node_d[SRC] ^ w_node_d[SRC+1];
                            2'b10:   r_d <= w_node_d[SRC];
                            2'b01:   r_d <= w_node_d[SRC+1];
                            default: r_d <= '0;
                        endcase
                    end
                end
            end else begin : g_pass
                always_ff @(posedge ap_clk) begin
                    if (ap_rst) begin
                        r_v <= 1'b0;
                        r_d <= '0;
                    end else begin
                        r_v <= w_node_v[SRC];
                        r_d <= w_node_d[SRC];
                    end
                end
            end

            assign w_node_v[DST] = r_v;
            assign w_node_d[DST] = r_d;
        end
    end

    logic                  w_tree_v;
    logic [FOLD_WIDTH-1:0] w_tree_d;
    assign w_tree_v = w_node_v[ROOT];
    assign w_tree_d = w_node_d[ROOT];

    logic [FOLD_WIDTH-1:0] r_sig;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [FOLD_WIDTH-1:0] w_sig_base;
    logic [FOLD_WIDTH-1:0] w_sig_next;
    logic [CNT_WIDTH-1:0]  w_cnt_next;

    // NOTE: blocking assignments here build the saturating increment chain one
    // channel at a time; every output gets its value before any conditional use.
    always_comb begin
        w_sig_base = bus.run_start ? '0 : r_sig;
        w_sig_next = w_tree_v ? (rotl1(w_sig_base) ^ w_tree_d) : w_sig_base;
        w_cnt_next = bus.run_start ? '0 : r_cnt;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.ch_write[i] && (w_cnt_next != CNT_MAX)) begin
                w_cnt_next = w_cnt_next + CNT_WIDTH'(1);
            end
        end
    end

    logic [DONE_DLY-1:0]   r_done_sr;
    logic                  w_done_exit;
    logic [OUT_WIDTH-1:0]  r_data_out;
    logic                  r_data_valid;
    logic [FOLD_WIDTH-1:0] r_sig_out;
    logic [CNT_WIDTH-1:0]  r_beat_cnt;
    logic                  r_sig_valid;

    // run_done lines up with the last beat it covers reaching the accumulators.
    assign w_done_exit = r_done_sr[DONE_DLY-1];

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_sig        <= '0;
            r_cnt        <= '0;
            r_done_sr    <= '0;
            r_sig_out    <= '0;
            r_beat_cnt   <= '0;
            r_sig_valid  <= 1'b0;
        end else begin
            r_data_out   <= fold_out(w_tree_d);
            r_data_valid <= w_tree_v;
            r_sig        <= w_sig_next;
            r_cnt        <= w_cnt_next;
            r_done_sr    <= (r_done_sr << 1) | DONE_DLY'(bus.run_done);
            r_sig_valid  <= w_done_exit;
            if (w_done_exit) begin
                r_sig_out  <= w_sig_next;
                r_beat_cnt <= w_cnt_next;
            end
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
    assign bus.sig_out    = r_sig_out;
    assign bus.beat_cnt   = r_beat_cnt;
    assign bus.sig_valid  = r_sig_valid;
endmodule
